pc_gen: RTL and testbench

Pre-IF program-counter generator; the consumer of the 3-bit `PCSel` code produced in PRE_IF. Holds the architectural fetch PC and issues instruction-fetch requests on an SRAM-like `req`/`addr_ok` interface. Applies redirects (jump, branch, JR, ERET, exception, refetch) according to `PCSel`. Keeps the request address stable until it is accepted, buffering any redirect that arrives while a request is outstanding, and tells IF whether each accepted fetch is live or stale.

---
 rtl/pc_gen.sv | 175 +++++++++++++++++
 tb/tb_pc_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - pre-IF fetch PC generator with req/addr_ok handshake; optional PCGEN_ALIGN_CHECK_EN
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  PCSel,
    input  logic [31:0] ImmeJump_Addr,
    input  logic [31:0] EPC,
    input  logic [31:0] Except_Addr,
    input  logic [31:0] Branch_Addr,
    input  logic [31:0] JR_Addr,
    input  logic [31:0] MEM_PC,
    input  logic        IF_Allowin,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    output logic        PC_Valid,
    output logic [31:0] PC_Out,
    output logic        Stale_Drop,
    output logic        PC_AdEL
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_IDLE = 3'd1,
        S_REQ  = 3'd2,
        S_PEND = 3'd3
`ifdef PCGEN_ALIGN_CHECK_EN
        ,
        S_ERR  = 3'd4
`endif
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] pend_pc, pend_n;
    logic        req_n;
    logic [31:0] addr_n;
    logic        valid_n;
    logic        stale_n;
    logic [31:0] out_n;
    logic        adel_n;

    logic        redirect;
    logic [31:0] target;
    logic        issue_en;
    logic        accept_en;
    logic [31:0] next_addr;

    // Decode PCSel into a redirect flag and its target; 000 and 111 are not redirects
    always_comb begin
        redirect = 1'b1;
        target   = 32'h0;
        case (PCSel)
            3'b001:  target = ImmeJump_Addr;
            3'b010:  target = EPC;
            3'b011:  target = Except_Addr;
            3'b100:  target = Branch_Addr;
            3'b101:  target = JR_Addr;
            3'b110:  target = MEM_PC;
            default: redirect = 1'b0;
        endcase
    end

    // Next-state and registered-output logic; a new address is either issued or parked in PC
    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        pend_n    = pend_pc;
        req_n     = inst_req;
        addr_n    = inst_addr;
        valid_n   = 1'b0;
        stale_n   = 1'b0;
        out_n     = PC_Out;
        adel_n    = 1'b0;
        issue_en  = 1'b0;
        accept_en = 1'b0;
        next_addr = pc_q;

        case (state)
            S_RST: state_n = S_IDLE;
            S_IDLE: begin
                next_addr = redirect ? target : pc_q;
                issue_en  = 1'b1;
            end
            S_REQ: begin
                if (inst_addr_ok) begin
                    out_n     = inst_addr;
                    accept_en = 1'b1;
                    if (redirect) begin
                        stale_n   = 1'b1;
                        next_addr = target;
                    end else begin
                        valid_n   = 1'b1;
                        next_addr = inst_addr + 32'd4;
                    end
                end else if (redirect) begin
                    // Address must stay stable; remember where to go once accepted
                    pend_n  = target;
                    state_n = S_PEND;
                end
            end
            S_PEND: begin
                if (inst_addr_ok) begin
                    stale_n   = 1'b1;
                    out_n     = inst_addr;
                    accept_en = 1'b1;
                    next_addr = redirect ? target : pend_pc;
                end else if (redirect) begin
                    pend_n = target;
                end
            end
`ifdef PCGEN_ALIGN_CHECK_EN
            S_ERR: begin
                if (redirect) begin
                    next_addr = target;
                    issue_en  = 1'b1;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

`ifdef PCGEN_ALIGN_CHECK_EN
        // A misaligned address is reported only from an idle slot so the fault
        // pulse never collides with the accept pulse of the previous fetch
        if (issue_en && (next_addr[1:0] != 2'b00)) begin
            pc_n    = next_addr;
            req_n   = 1'b0;
            valid_n = 1'b1;
            adel_n  = 1'b1;
            out_n   = next_addr;
            state_n = S_ERR;
        end else if ((issue_en || accept_en) && IF_Allowin && (next_addr[1:0] == 2'b00)) begin
`else
        if ((issue_en || accept_en) && IF_Allowin) begin
`endif
            pc_n    = next_addr;
            addr_n  = next_addr;
            req_n   = 1'b1;
            state_n = S_REQ;
        end else if (issue_en || accept_en) begin
            pc_n    = next_addr;
            req_n   = 1'b0;
            state_n = S_IDLE;
        end
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_RST;
            pc_q       <= RESET_PC;
            pend_pc    <= 32'h0;
            inst_req   <= 1'b0;
            inst_addr  <= 32'h0;
            PC_Valid   <= 1'b0;
            PC_Out     <= 32'h0;
            Stale_Drop <= 1'b0;
            PC_AdEL    <= 1'b0;
        end else begin
            state      <= state_n;
            pc_q       <= pc_n;
            pend_pc    <= pend_n;
            inst_req   <= req_n;
            inst_addr  <= addr_n;
            PC_Valid   <= valid_n;
            PC_Out     <= out_n;
            Stale_Drop <= stale_n;
            PC_AdEL    <= adel_n;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed scoreboard bench for pc_gen
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic [2:0]  PCSel;
    logic [31:0] ImmeJump_Addr, EPC, Except_Addr, Branch_Addr, JR_Addr, MEM_PC;
    logic        IF_Allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        PC_Valid;
    logic [31:0] PC_Out;
    logic        Stale_Drop;
    logic        PC_AdEL;

    typedef struct {
        logic        v;
        logic        s;
        logic        a;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_en = 1'b0;

    pc_gen dut (
        .clk          (clk),
        .resetn       (resetn),
        .PCSel        (PCSel),
        .ImmeJump_Addr(ImmeJump_Addr),
        .EPC          (EPC),
        .Except_Addr  (Except_Addr),
        .Branch_Addr  (Branch_Addr),
        .JR_Addr      (JR_Addr),
        .MEM_PC       (MEM_PC),
        .IF_Allowin   (IF_Allowin),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .PC_Valid     (PC_Valid),
        .PC_Out       (PC_Out),
        .Stale_Drop   (Stale_Drop),
        .PC_AdEL      (PC_AdEL)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic v, input logic s, input logic a, input logic [31:0] pc);
        exp_t e;
        e.v  = v;
        e.s  = s;
        e.a  = a;
        e.pc = pc;
        sb.push_back(e);
    endtask

    // Pop the expected pulse whenever the DUT reports an accepted or faulted fetch
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && (PC_Valid || Stale_Drop)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'b0, PC_Valid, Stale_Drop, PC_AdEL}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {29'b0, PC_Valid, Stale_Drop, PC_AdEL}, {29'b0, e.v, e.s, e.a});
                chk("pulse_pc", PC_Out, e.pc);
            end
        end
    end

    initial begin
        resetn        = 1'b0;
        PCSel         = 3'b000;
        inst_addr_ok  = 1'b0;
        IF_Allowin    = 1'b0;
        ImmeJump_Addr = 32'h8000_1000;
        EPC           = 32'h8000_2000;
        Except_Addr   = 32'hBFC0_0380;
        Branch_Addr   = 32'h8000_0100;
        JR_Addr       = 32'h0;
        MEM_PC        = 32'h0;
        tick();
        tick();
        chk("rst_req", inst_req, 32'h0);
        chk("rst_addr", inst_addr, 32'h0);
        chk("rst_valid", PC_Valid, 32'h0);
        chk("rst_out", PC_Out, 32'h0);
        chk("rst_stale", Stale_Drop, 32'h0);
        chk("rst_adel", PC_AdEL, 32'h0);

        resetn       = 1'b1;
        IF_Allowin   = 1'b1;
        inst_addr_ok = 1'b1;
        mon_en       = 1'b1;
        tick();
        chk("first_cycle_no_req", inst_req, 32'h0);
        tick();
        chk("first_req", inst_req, 32'h1);
        chk("first_addr", inst_addr, 32'hBFC0_0000);
        expect_pulse(1'b1, 1'b0, 1'b0, 32'hBFC0_0000);
        tick();
        chk("seq_addr1", inst_addr, 32'hBFC0_0004);
        expect_pulse(1'b1, 1'b0, 1'b0, 32'hBFC0_0004);
        tick();
        chk("seq_addr2", inst_addr, 32'hBFC0_0008);

        // Branch while the request is not accepted
        inst_addr_ok = 1'b0;
        PCSel        = 3'b100;
        tick();
        chk("hold_addr1", inst_addr, 32'hBFC0_0008);
        PCSel = 3'b000;
        tick();
        tick();
        chk("hold_addr3", inst_addr, 32'hBFC0_0008);
        chk("hold_req", inst_req, 32'h1);
        inst_addr_ok = 1'b1;
        expect_pulse(1'b0, 1'b1, 1'b0, 32'hBFC0_0008);
        tick();
        chk("branch_addr", inst_addr, 32'h8000_0100);

        // Two redirects while pending; the newest wins
        inst_addr_ok = 1'b0;
        PCSel        = 3'b011;
        tick();
        PCSel = 3'b000;
        tick();
        PCSel = 3'b010;
        tick();
        chk("pend_hold", inst_addr, 32'h8000_0100);
        PCSel        = 3'b000;
        inst_addr_ok = 1'b1;
        expect_pulse(1'b0, 1'b1, 1'b0, 32'h8000_0100);
        tick();
        chk("epc_addr", inst_addr, 32'h8000_2000);

        // JR coincident with acceptance
        PCSel   = 3'b101;
        JR_Addr = 32'h8000_0040;
        expect_pulse(1'b0, 1'b1, 1'b0, 32'h8000_2000);
        tick();
        chk("jr_addr", inst_addr, 32'h8000_0040);

        // Wrap at the top of the address space with IF stalled
        JR_Addr = 32'hFFFF_FFFC;
        expect_pulse(1'b0, 1'b1, 1'b0, 32'h8000_0040);
        tick();
        chk("top_addr", inst_addr, 32'hFFFF_FFFC);
        PCSel      = 3'b000;
        IF_Allowin = 1'b0;
        expect_pulse(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        tick();
        chk("stall_req", inst_req, 32'h0);
        inst_addr_ok = 1'b0;
        IF_Allowin   = 1'b1;
        tick();
        chk("wrap_req", inst_req, 32'h1);
        chk("wrap_addr", inst_addr, 32'h0000_0000);
        inst_addr_ok = 1'b1;
        expect_pulse(1'b1, 1'b0, 1'b0, 32'h0000_0000);
        tick();
        chk("after_wrap_addr", inst_addr, 32'h0000_0004);

        // Redirect while idle
        IF_Allowin = 1'b0;
        expect_pulse(1'b1, 1'b0, 1'b0, 32'h0000_0004);
        tick();
        chk("idle_req", inst_req, 32'h0);
        inst_addr_ok = 1'b0;
        IF_Allowin   = 1'b1;
        PCSel        = 3'b001;
        tick();
        chk("idle_jump_req", inst_req, 32'h1);
        chk("idle_jump_addr", inst_addr, 32'h8000_1000);

        // MEMPC refetch, then reserved code behaves as PC4
        inst_addr_ok = 1'b1;
        PCSel        = 3'b110;
        MEM_PC       = 32'h8000_3000;
        expect_pulse(1'b0, 1'b1, 1'b0, 32'h8000_1000);
        tick();
        chk("mempc_addr", inst_addr, 32'h8000_3000);
        PCSel = 3'b111;
        expect_pulse(1'b1, 1'b0, 1'b0, 32'h8000_3000);
        tick();
        chk("reserved_addr", inst_addr, 32'h8000_3004);

        // Misaligned JR target
        PCSel   = 3'b101;
        JR_Addr = 32'h8000_0002;
        expect_pulse(1'b0, 1'b1, 1'b0, 32'h8000_3004);
        tick();
`ifdef PCGEN_ALIGN_CHECK_EN
        chk("mis_no_req", inst_req, 32'h0);
        PCSel = 3'b000;
        expect_pulse(1'b1, 1'b0, 1'b1, 32'h8000_0002);
        tick();
        chk("err_no_req", inst_req, 32'h0);
        tick();
        chk("err_stays", inst_req, 32'h0);
        PCSel        = 3'b011;
        inst_addr_ok = 1'b0;
        tick();
        chk("err_exit_req", inst_req, 32'h1);
        chk("err_exit_addr", inst_addr, 32'hBFC0_0380);
        PCSel = 3'b000;
`else
        chk("mis_req", inst_req, 32'h1);
        chk("mis_addr", inst_addr, 32'h8000_0002);
        PCSel = 3'b000;
        expect_pulse(1'b1, 1'b0, 1'b0, 32'h8000_0002);
        tick();
        chk("mis_next_addr", inst_addr, 32'h8000_0006);
`endif
        inst_addr_ok = 1'b0;
        tick();
        chk("sb_drained", sb.size(), 32'h0);

        // Asynchronous reset with a request outstanding
        mon_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_req", inst_req, 32'h0);
        chk("async_rst_addr", inst_addr, 32'h0);
        chk("async_rst_out", PC_Out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
